pcie_rx_tlp: RTL and testbench

Parametrised PCIe receive-side TLP parser for the 64-bit AXI-stream interface of the PCIe hard core. Decodes memory writes and reads with 3DW or 4DW headers and CplD completions, with multi-qword payloads. Emits one strobe per payload qword with an auto-incrementing qword address, and one strobe per read request. Unsupported or malformed TLPs are dropped and counted. Sits between the PCIe core RX stream and the register file and DMA completion logic.

---
 rtl/pcie_tlp_pkg.sv | 29 ++
 rtl/pcie_rx_hdr_decode.sv | 36 +++
 rtl/pcie_rx_tlp.sv | 189 ++++++++++++++++++
 tb/tb_pcie_rx_tlp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// Shared definitions for the PCIe TLP receive path: fmt/type codes, parser
// states, decoded TLP kinds and the payload DW byte swap.
package pcie_tlp_pkg;

   localparam logic [7:0] MWR32 = 8'h40;
   localparam logic [7:0] MWR64 = 8'h60;
   localparam logic [7:0] MRD32 = 8'h00;
   localparam logic [7:0] MRD64 = 8'h20;
   localparam logic [7:0] CPLD  = 8'h4A;

   typedef enum logic [1:0] {
      HDR0 = 2'd0,
      HDR1 = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      KIND_BAD  = 2'd0,
      KIND_MWR  = 2'd1,
      KIND_MRD  = 2'd2,
      KIND_CPLD = 2'd3
   } kind_t;

   function automatic logic [31:0] swap_dw(input logic [31:0] dw);
      return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
   endfunction

endpackage

// File: rtl/pcie_rx_hdr_decode.sv
// Combinational decode of TLP header DW0 into kind, 4DW flag and effective
// DW length (a zero length field means 1024 DW).
module pcie_rx_hdr_decode
   import pcie_tlp_pkg::*;
(
   input  logic [31:0] dw0,
   output kind_t       kind,
   output logic        is_4dw,
   output logic [10:0] length
);

   logic unused_bits;

   assign unused_bits = ^dw0[23:10];

   always_comb begin
      kind   = KIND_BAD;
      is_4dw = 1'b0;
      case (dw0[31:24])
         MWR32: kind = KIND_MWR;
         MWR64: begin
            kind   = KIND_MWR;
            is_4dw = 1'b1;
         end
         MRD32: kind = KIND_MRD;
         MRD64: begin
            kind   = KIND_MRD;
            is_4dw = 1'b1;
         end
         CPLD:    kind = KIND_CPLD;
         default: kind = KIND_BAD;
      endcase
      length = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
   end

endmodule

// File: rtl/pcie_rx_tlp.sv
// Receive-side TLP parser for the 64-bit PCIe core RX stream: emits write,
// read-request and completion strobes, and drops/counts everything else.
module pcie_rx_tlp
   import pcie_tlp_pkg::*;
#(
   parameter int ADDR_WIDTH  = 13,
   parameter int SWAP_ENDIAN = 1,
   parameter int MAX_READ_DW = 2
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  tvalid,
   input  logic                  tlast,
   input  logic [63:0]           tdata,
   output logic                  write_valid,
   output logic                  read_valid,
   output logic                  completion_valid,
   output logic [63:0]           data,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [9:0]            read_length,
   output logic [23:0]           rid_tag,
   output logic                  drop_valid,
   output logic [15:0]           drop_count
);

   localparam logic [10:0] MAX_READ_LEN = 11'(MAX_READ_DW);

   logic                  tvalid_q;
   logic                  tlast_q;
   logic [63:0]           tdata_q;
   logic [31:0]           prev_hi;
   state_t                state, state_next, adv_state;
   kind_t                 dec_kind, hdr_kind;
   logic                  dec_4dw, hdr_4dw;
   logic [10:0]           dec_len, hdr_len;
   logic [9:0]            remaining, remaining_next;
   logic [ADDR_WIDTH-1:0] qaddr, qaddr_next, hdr_addr;
   logic [31:0]           addr_dw;
   logic [63:0]           raw_qword, payload;
   logic                  read_ok, payload_ok;
   logic                  emit_write, emit_read, emit_cpl, emit_drop;
   logic                  load_hdr, load_req_tag, load_cpl_tag;
   logic                  unused_bits;

   pcie_rx_hdr_decode u_hdr_decode (
      .dw0    (tdata_q[31:0]),
      .kind   (dec_kind),
      .is_4dw (dec_4dw),
      .length (dec_len)
   );

   // The address DW sits in DW2 (3DW) or DW3 (4DW) of header beat 1.
   assign addr_dw    = hdr_4dw ? tdata_q[63:32] : tdata_q[31:0];
   assign hdr_addr   = addr_dw[ADDR_WIDTH+2:3];
   assign read_ok    = (hdr_len <= MAX_READ_LEN) && (addr_dw[1:0] == 2'b00);
   assign payload_ok = !hdr_len[0] && !addr_dw[2];
   assign raw_qword  = hdr_4dw ? tdata_q : {tdata_q[31:0], prev_hi};
   assign payload    = (SWAP_ENDIAN != 0) ?
                       {swap_dw(raw_qword[63:32]), swap_dw(raw_qword[31:0])} : raw_qword;
   assign unused_bits = ^{tdata_q[39:32], addr_dw};

   // Input beat register and parser state.
   always_ff @(posedge clock) begin
      if (reset) begin
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tdata_q   <= 64'd0;
         prev_hi   <= 32'd0;
         state     <= HDR0;
         hdr_kind  <= KIND_BAD;
         hdr_4dw   <= 1'b0;
         hdr_len   <= 11'd0;
         remaining <= 10'd0;
         qaddr     <= '0;
      end else begin
         tvalid_q  <= tvalid;
         tlast_q   <= tlast;
         tdata_q   <= tdata;
         prev_hi   <= tvalid_q ? tdata_q[63:32] : prev_hi;
         state     <= state_next;
         remaining <= remaining_next;
         qaddr     <= qaddr_next;
         if (load_hdr) begin
            hdr_kind <= dec_kind;
            hdr_4dw  <= dec_4dw;
            hdr_len  <= dec_len;
         end
      end
   end

   // Next-state and strobe decode; only valid beats advance the parser.
   always_comb begin
      adv_state      = state;
      state_next     = state;
      remaining_next = remaining;
      qaddr_next     = qaddr;
      emit_write     = 1'b0;
      emit_read      = 1'b0;
      emit_cpl       = 1'b0;
      emit_drop      = 1'b0;
      load_hdr       = 1'b0;
      load_req_tag   = 1'b0;
      load_cpl_tag   = 1'b0;
      if (tvalid_q) begin
         case (state)
            HDR0: begin
               load_hdr = 1'b1;
               if (dec_kind == KIND_BAD) begin
                  emit_drop = 1'b1;
                  adv_state = DROP;
               end else begin
                  load_req_tag = (dec_kind != KIND_CPLD);
                  adv_state    = HDR1;
               end
            end
            HDR1: begin
               load_cpl_tag = (hdr_kind == KIND_CPLD);
               if (hdr_kind == KIND_MRD) begin
                  // A read carries no payload; DATA with nothing left just waits for tlast.
                  emit_read      = read_ok;
                  emit_drop      = !read_ok;
                  remaining_next = 10'd0;
                  adv_state      = DATA;
               end else if (payload_ok) begin
                  remaining_next = hdr_len[10:1];
                  qaddr_next     = (hdr_kind == KIND_CPLD) ? '0 : hdr_addr;
                  adv_state      = DATA;
               end else begin
                  emit_drop = 1'b1;
                  adv_state = DROP;
               end
            end
            DATA: begin
               if (remaining != 10'd0) begin
                  emit_write     = (hdr_kind == KIND_MWR);
                  emit_cpl       = (hdr_kind == KIND_CPLD);
                  remaining_next = remaining - 10'd1;
                  qaddr_next     = qaddr + ADDR_WIDTH'(1);
               end else begin
                  adv_state = DATA;
               end
            end
            DROP:    adv_state = DROP;
            default: adv_state = HDR0;
         endcase
         state_next = tlast_q ? HDR0 : adv_state;
      end else begin
         state_next = state;
      end
   end

   // Registered outputs and the saturating drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_valid      <= 1'b0;
         read_valid       <= 1'b0;
         completion_valid <= 1'b0;
         drop_valid       <= 1'b0;
         data             <= 64'd0;
         address          <= '0;
         read_length      <= 10'd0;
         rid_tag          <= 24'd0;
         drop_count       <= 16'd0;
      end else begin
         write_valid      <= emit_write;
         read_valid       <= emit_read;
         completion_valid <= emit_cpl;
         drop_valid       <= emit_drop;
         if (emit_write || emit_cpl) begin
            data    <= payload;
            address <= qaddr;
         end else if (emit_read) begin
            address     <= hdr_addr;
            read_length <= hdr_len[9:0];
         end
         if (load_req_tag) begin
            rid_tag <= tdata_q[63:40];
         end else if (load_cpl_tag) begin
            rid_tag <= tdata_q[31:8];
         end
         if (emit_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end else begin
            drop_count <= drop_count;
         end
      end
   end

endmodule

// File: tb/tb_pcie_rx_tlp.sv
// Directed bench for pcie_rx_tlp: a per-cycle vector table of beats and the
// outputs expected two cycles later, plus saturation and reset sequences.
module tb_pcie_rx_tlp;

   logic        clock;
   logic        reset;
   logic        tvalid;
   logic        tlast;
   logic [63:0] tdata;
   logic        write_valid;
   logic        read_valid;
   logic        completion_valid;
   logic [63:0] data;
   logic [12:0] address;
   logic [9:0]  read_length;
   logic [23:0] rid_tag;
   logic        drop_valid;
   logic [15:0] drop_count;

   int total = 0;
   int bad   = 0;

   pcie_rx_tlp #(
      .ADDR_WIDTH  (13),
      .SWAP_ENDIAN (1),
      .MAX_READ_DW (2)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .tvalid           (tvalid),
      .tlast            (tlast),
      .tdata            (tdata),
      .write_valid      (write_valid),
      .read_valid       (read_valid),
      .completion_valid (completion_valid),
      .data             (data),
      .address          (address),
      .read_length      (read_length),
      .rid_tag          (rid_tag),
      .drop_valid       (drop_valid),
      .drop_count       (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        v;
      logic        l;
      logic [63:0] d;
      logic        chk;
      logic        w;
      logic        r;
      logic        c;
      logic        dr;
      logic [12:0] addr;
      logic [63:0] data;
      logic        chk_tag;
      logic [23:0] tag;
      logic [9:0]  rlen;
      logic        chk_dc;
      logic [15:0] dc;
   } vec_t;

   vec_t vecs[$];

   // Monitor used by the hand-written sequences.
   logic        mon_en = 1'b0;
   int          nw = 0;
   int          nd = 0;
   int          no = 0;
   logic [12:0] last_addr = 13'd0;
   logic [63:0] last_data = 64'd0;

   always @(negedge clock) begin
      if (mon_en) begin
         if (write_valid) begin
            nw        <= nw + 1;
            last_addr <= address;
            last_data <= data;
         end
         if (drop_valid) nd <= nd + 1;
         if (read_valid || completion_valid) no <= no + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic r, input logic v, input logic l, input logic [63:0] d);
      vec_t e;
      e = '{default: '0};
      e.rst = r; e.v = v; e.l = l; e.d = d; e.chk = 1'b1;
      vecs.push_back(e);
   endtask

   // Expectations are attached to the row two cycles after the completing beat.
   task automatic set_w(input int b, input logic [12:0] a, input logic [63:0] q);
      vecs[b+2].w = 1'b1; vecs[b+2].addr = a; vecs[b+2].data = q;
   endtask

   task automatic set_c(input int b, input logic [12:0] a, input logic [63:0] q, input logic [23:0] t);
      vecs[b+2].c = 1'b1; vecs[b+2].addr = a; vecs[b+2].data = q;
      vecs[b+2].chk_tag = 1'b1; vecs[b+2].tag = t;
   endtask

   task automatic set_r(input int b, input logic [12:0] a, input logic [9:0] n, input logic [23:0] t);
      vecs[b+2].r = 1'b1; vecs[b+2].addr = a; vecs[b+2].rlen = n;
      vecs[b+2].chk_tag = 1'b1; vecs[b+2].tag = t;
   endtask

   task automatic set_drop(input int b, input logic [15:0] cnt);
      vecs[b+2].dr = 1'b1; vecs[b+2].chk_dc = 1'b1; vecs[b+2].dc = cnt;
   endtask

   task automatic drive(input logic r, input logic v, input logic l, input logic [63:0] d);
      @(negedge clock);
      reset = r; tvalid = v; tlast = l; tdata = d;
   endtask

   initial begin
      reset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = 64'd0;

      push(1'b1, 1'b0, 1'b0, 64'd0);                    // 0
      push(1'b1, 1'b0, 1'b0, 64'd0);                    // 1
      push(1'b0, 1'b0, 1'b0, 64'd0);                    // 2
      push(1'b0, 1'b1, 1'b0, 64'h010001FF_40000004);    // 3  3DW MWr len 4 @0x100
      push(1'b0, 1'b1, 1'b0, 64'h11223344_00000100);    // 4
      push(1'b0, 1'b1, 1'b0, 64'h99AABBCC_55667788);    // 5
      push(1'b0, 1'b1, 1'b1, 64'h00000000_DDEEFF00);    // 6
      push(1'b0, 1'b1, 1'b0, 64'h010002FF_60000002);    // 7  4DW MWr len 2 @0x1_0000_0008
      push(1'b0, 1'b1, 1'b0, 64'h00000008_00000001);    // 8
      push(1'b0, 1'b1, 1'b1, 64'hCAFEBABE_12345678);    // 9
      push(1'b0, 1'b1, 1'b0, 64'h010007FF_00000002);    // 10 3DW MRd len 2 @0x18
      push(1'b0, 1'b1, 1'b1, 64'h00000000_00000018);    // 11
      push(1'b0, 1'b1, 1'b0, 64'h010008FF_00000003);    // 12 MRd len 3 (too long)
      push(1'b0, 1'b1, 1'b1, 64'h00000000_00000018);    // 13
      push(1'b0, 1'b1, 1'b0, 64'h00000020_4A000008);    // 14 CplD len 8 tag 0x2A
      push(1'b0, 1'b1, 1'b0, 64'hA0B0C000_01002A00);    // 15
      push(1'b0, 1'b1, 1'b0, 64'hA0B0C002_A0B0C001);    // 16
      push(1'b0, 1'b1, 1'b0, 64'hA0B0C004_A0B0C003);    // 17
      push(1'b0, 1'b1, 1'b0, 64'hA0B0C006_A0B0C005);    // 18
      push(1'b0, 1'b1, 1'b1, 64'h00000000_A0B0C007);    // 19
      push(1'b0, 1'b1, 1'b0, 64'h010003FF_40000002);    // 20 3DW MWr len 2 @0x40, back-to-back
      push(1'b0, 1'b1, 1'b0, 64'h01020304_00000040);    // 21
      push(1'b0, 1'b1, 1'b1, 64'h00000000_05060708);    // 22
      push(1'b0, 1'b1, 1'b0, 64'h010004FF_30000000);    // 23 message TLP
      push(1'b0, 1'b1, 1'b0, 64'h00000000_00000000);    // 24
      push(1'b0, 1'b1, 1'b1, 64'h00000000_00000000);    // 25
      push(1'b0, 1'b1, 1'b0, 64'h010005FF_40000003);    // 26 MWr odd length
      push(1'b0, 1'b1, 1'b0, 64'hDEADBEEF_00000040);    // 27
      push(1'b0, 1'b1, 1'b0, 64'h00000000_00000000);    // 28
      push(1'b0, 1'b1, 1'b1, 64'h00000000_00000000);    // 29
      push(1'b0, 1'b0, 1'b0, 64'd0);                    // 30
      push(1'b0, 1'b0, 1'b0, 64'd0);                    // 31
      push(1'b0, 1'b0, 1'b0, 64'd0);                    // 32

      vecs[0].chk = 1'b0;
      vecs[1].chk_dc = 1'b1; vecs[1].dc = 16'd0;
      set_w(5,  13'h020, 64'h8877665544332211);
      set_w(6,  13'h021, 64'h00FFEEDDCCBBAA99);
      set_w(9,  13'h001, 64'hBEBAFECA78563412);
      set_r(11, 13'h003, 10'd2, 24'h010007);
      set_drop(13, 16'd1);
      set_c(16, 13'h000, 64'h01C0B0A0_00C0B0A0, 24'h01002A);
      set_c(17, 13'h001, 64'h03C0B0A0_02C0B0A0, 24'h01002A);
      set_c(18, 13'h002, 64'h05C0B0A0_04C0B0A0, 24'h01002A);
      set_c(19, 13'h003, 64'h07C0B0A0_06C0B0A0, 24'h01002A);
      set_w(22, 13'h008, 64'h0807060504030201);
      set_drop(23, 16'd2);
      set_drop(27, 16'd3);
      vecs[32].chk_dc = 1'b1; vecs[32].dc = 16'd3;

      // Check the outputs of this cycle, then drive this row's beat.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         if (vecs[i].chk) begin
            check($sformatf("r%0d write_valid", i), 64'(write_valid), 64'(vecs[i].w));
            check($sformatf("r%0d read_valid", i), 64'(read_valid), 64'(vecs[i].r));
            check($sformatf("r%0d completion_valid", i), 64'(completion_valid), 64'(vecs[i].c));
            check($sformatf("r%0d drop_valid", i), 64'(drop_valid), 64'(vecs[i].dr));
            if (vecs[i].w || vecs[i].c) begin
               check($sformatf("r%0d address", i), 64'(address), 64'(vecs[i].addr));
               check($sformatf("r%0d data", i), data, vecs[i].data);
            end
            if (vecs[i].r) begin
               check($sformatf("r%0d read address", i), 64'(address), 64'(vecs[i].addr));
               check($sformatf("r%0d read_length", i), 64'(read_length), 64'(vecs[i].rlen));
            end
            if (vecs[i].chk_tag) begin
               check($sformatf("r%0d rid_tag", i), 64'(rid_tag), 64'(vecs[i].tag));
            end
            if (vecs[i].chk_dc) begin
               check($sformatf("r%0d drop_count", i), 64'(drop_count), 64'(vecs[i].dc));
            end
            if (vecs[i].rst) begin
               check($sformatf("r%0d reset data", i), data, 64'd0);
               check($sformatf("r%0d reset address", i), 64'(address), 64'd0);
               check($sformatf("r%0d reset rid_tag", i), 64'(rid_tag), 64'd0);
               check($sformatf("r%0d reset read_length", i), 64'(read_length), 64'd0);
            end
         end
         reset = vecs[i].rst; tvalid = vecs[i].v; tlast = vecs[i].l; tdata = vecs[i].d;
      end

      // Saturation: preload the counter at its maximum, then drop one more TLP.
      @(negedge clock);
      force dut.drop_count = 16'hFFFF;
      @(negedge clock);
      release dut.drop_count;
      drive(1'b0, 1'b1, 1'b1, 64'h010009FF_30000000);
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      @(negedge clock);
      check("sat drop_valid", 64'(drop_valid), 64'd1);
      check("sat drop_count", 64'(drop_count), 64'hFFFF);

      // Reset during beat 1 of a 4DW MWr, then a clean 3DW MWr.
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      mon_en = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 64'h010006FF_60000002);
      drive(1'b1, 1'b1, 1'b0, 64'h00000010_00000000);
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      check("rst strobes", 64'({write_valid, read_valid, completion_valid, drop_valid}), 64'd0);
      check("rst drop_count", 64'(drop_count), 64'd0);
      drive(1'b0, 1'b1, 1'b1, 64'h11111111_40000001);
      drive(1'b0, 1'b1, 1'b0, 64'h01000AFF_40000002);
      drive(1'b0, 1'b1, 1'b0, 64'hAABBCCDD_00000080);
      drive(1'b0, 1'b1, 1'b1, 64'h00000000_11223344);
      for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 64'd0);
      mon_en = 1'b0;
      check("post-rst write count", 64'(nw), 64'd1);
      check("post-rst address", 64'(last_addr), 64'h010);
      check("post-rst data", last_data, 64'h44332211_DDCCBBAA);
      check("post-rst drops", 64'(nd), 64'd0);
      check("post-rst other strobes", 64'(no), 64'd0);
      check("post-rst drop_count", 64'(drop_count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
